multi_debounce: RTL and testbench

//   N-channel parametrised switch/button debouncer. A shared prescaler produces a periodic sample

---
 rtl/multi_debounce.sv | 93 +++++++++
 tb/tb_multi_debounce.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// multi_debounce: N-channel switch debouncer with shared sample-tick prescaler, per-channel synchroniser and 4-state FSM
module multi_debounce #(
  parameter int N_CH        = 4,
  parameter int TICK_DIV    = 500000,
  parameter int N_TICKS     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(N_TICKS + 1);
  localparam logic [1:0] ST0 = 2'b00;
  localparam logic [1:0] WT1 = 2'b01;
  localparam logic [1:0] ST1 = 2'b11;
  localparam logic [1:0] WT0 = 2'b10;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q;
  assign pre_d = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + 1'b1;
  assign tick  = tick_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= (pre_q == PW'(TICK_DIV - 1));
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, rise_q, fall_q;
    logic                   s, last;
    assign s    = sync_q[SYNC_STAGES-1];
    assign last = (cnt_q == CW'(N_TICKS - 1));
    // a tick only counts while s still sits at the level being qualified
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST0: if (s) begin
          state_d = WT1;
          cnt_d   = '0;
        end
        WT1: if (!s) begin
          state_d = ST0;
          cnt_d   = '0;
        end else if (tick_q) begin
          state_d = last ? ST1 : WT1;
          cnt_d   = last ? '0 : cnt_q + 1'b1;
        end
        ST1: if (!s) begin
          state_d = WT0;
          cnt_d   = '0;
        end
        default: if (s) begin
          state_d = ST1;
          cnt_d   = '0;
        end else if (tick_q) begin
          state_d = last ? ST0 : WT0;
          cnt_d   = last ? '0 : cnt_q + 1'b1;
        end
      endcase
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q  <= '0;
        state_q <= ST0;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        sync_q  <= SYNC_STAGES'({sync_q, sw[i]});
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= (state_d == ST1) || (state_d == WT0);
        rise_q  <= (state_q == WT1) && (state_d == ST1);
        fall_q  <= (state_q == WT0) && (state_d == ST0);
      end
    end
    assign db[i]   = db_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end
endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: phase table, hand-written corner sequences and random stimulus against a run-length reference model
module tb_multi_debounce;
  localparam int NC = 4, TD = 4, NT = 3, SS = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [NC-1:0] sw = '0, db, rise, fall;
  logic tick;
  multi_debounce #(.N_CH(NC), .TICK_DIV(TD), .N_TICKS(NT), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sw(sw), .db(db), .rise(rise), .fall(fall), .tick(tick)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] sw;
    int         hold;
    logic [3:0] db;
    logic [3:0] rose;
    logic [3:0] fell;
  } vec_t;
  vec_t tbl[6];
  int n_chk = 0, n_fail = 0;
  int e;
  logic [3:0] hist[$];
  logic [3:0] m_lvl, m_rise, m_fall;
  int m_run[NC], m_k[NC];
  int rc[NC], fc[NC];
  logic [3:0] db_or, db_and;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    e = 0;
    hist = '{4'b0, 4'b0};
    m_lvl = '0;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < NC; c++) begin
      m_run[c] = 0;
      m_k[c] = 0;
    end
  endtask
  // level commits after NT ticks seen while the synchronised input differs from it, ignoring the first differing cycle
  task automatic model_edge(input logic [3:0] v);
    logic [3:0] s;
    bit tk;
    s = hist[0];
    void'(hist.pop_front());
    hist.push_back(v);
    tk = (e > 0) && (e % TD == 0);
    e++;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < NC; c++) begin
      if (s[c] == m_lvl[c]) begin
        m_run[c] = 0;
        m_k[c] = 0;
      end else begin
        m_run[c]++;
        if (m_run[c] >= 2 && tk) m_k[c]++;
        if (m_k[c] == NT) begin
          m_lvl[c] = s[c];
          if (s[c]) m_rise[c] = 1'b1;
          else m_fall[c] = 1'b1;
          m_run[c] = 0;
          m_k[c] = 0;
        end
      end
    end
  endtask
  task automatic clr();
    for (int c = 0; c < NC; c++) begin
      rc[c] = 0;
      fc[c] = 0;
    end
    db_or = '0;
    db_and = '1;
  endtask
  task automatic cyc(input logic [3:0] v);
    sw = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
    chk("db", db, m_lvl);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("tick", tick, (e > 0) && (e % TD == 0));
    for (int c = 0; c < NC; c++) begin
      rc[c] += int'(rise[c]);
      fc[c] += int'(fall[c]);
    end
    db_or |= db;
    db_and &= db;
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_db", db, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    logic [3:0] r_got, f_got, multi, v;
    int w, rate;
    tbl[0] = '{4'b0000, 100, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0001, 20, 4'b0001, 4'b0001, 4'b0000};
    tbl[2] = '{4'b0101, 20, 4'b0101, 4'b0100, 4'b0000};
    tbl[3] = '{4'b0100, 4, 4'b0101, 4'b0000, 4'b0000};
    tbl[4] = '{4'b0101, 20, 4'b0101, 4'b0000, 4'b0000};
    tbl[5] = '{4'b1111, 20, 4'b1111, 4'b1010, 4'b0000};
    @(negedge clk);
    rst_pulse();
    for (int p = 0; p < 6; p++) begin
      clr();
      repeat (tbl[p].hold) cyc(tbl[p].sw);
      r_got = '0;
      f_got = '0;
      multi = '0;
      for (int c = 0; c < NC; c++) begin
        r_got[c] = rc[c] != 0;
        f_got[c] = fc[c] != 0;
        multi[c] = rc[c] > 1 || fc[c] > 1;
      end
      chk($sformatf("phase%0d_db", p), db, tbl[p].db);
      chk($sformatf("phase%0d_rose", p), r_got, tbl[p].rose);
      chk($sformatf("phase%0d_fell", p), f_got, tbl[p].fell);
      chk($sformatf("phase%0d_multi", p), multi, 0);
    end
    clr();
    repeat (20) cyc(4'b0000);
    chk("all_down_fc", {fc[3][7:0], fc[2][7:0], fc[1][7:0], fc[0][7:0]}, 32'h01010101);
    rst_pulse();
    clr();
    for (int t = 0; t < 40; t++) cyc(((t / 3) % 2 == 0) ? 4'b0010 : 4'b0000);
    repeat (20) cyc(4'b0000);
    chk("toggle_db1_never", db_or[1], 0);
    chk("toggle_rise1", rc[1], 0);
    chk("toggle_fall1", fc[1], 0);
    repeat (20) cyc(4'b0100);
    chk("ch2_up", db[2], 1);
    clr();
    repeat (5) cyc(4'b0000);
    repeat (20) cyc(4'b0100);
    chk("ch2_glitch_held", db_and[2], 1);
    chk("ch2_glitch_fall", fc[2], 0);
    repeat (20) cyc(4'b0000);
    w = 0;
    cyc(4'b1111);
    while (rise == 0 && w < 30) begin
      cyc(4'b1111);
      w++;
    end
    chk("all_rise_same", rise, 4'b1111);
    repeat (5) cyc(4'b1111);
    w = 0;
    cyc(4'b0000);
    while (fall == 0 && w < 30) begin
      cyc(4'b0000);
      w++;
    end
    chk("all_fall_same", fall, 4'b1111);
    rst_pulse();
    w = 0;
    cyc(4'b0001);
    while (m_k[0] != 2 && w < 40) begin
      cyc(4'b0001);
      w++;
    end
    chk("reach_wait1_cnt2", w < 40, 1);
    rst_pulse();
    clr();
    repeat (11) cyc(4'b0001);
    chk("requal_db_low", db[0], 0);
    chk("requal_no_rise", rc[0], 0);
    repeat (12) cyc(4'b0001);
    chk("requal_db_high", db[0], 1);
    chk("requal_one_rise", rc[0], 1);
    v = 4'b0001;
    for (int b = 0; b < 10; b++) begin
      rate = $urandom_range(30, 3);
      for (int t = 0; t < 100; t++) begin
        for (int c = 0; c < NC; c++)
          if ($urandom_range(rate - 1) == 0) v[c] = ~v[c];
        cyc(v);
      end
      if (b == 5) rst_pulse();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
